// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, 2-FF row sync, frame debounce, press strobe.
// Optional entry register enabled by defining KEYPAD_ENTRY_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 120,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_pins,
  output logic [3:0]  col_select,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  input  logic        entry_clr,
  output logic [15:0] entry
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_sel_q, col_sel_d;
  logic [15:0]      frame_q, frame_d, frame_full_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             tick_s, frame_done_s, empty_s, single_s;
  logic [4:0]       ones_s;
  logic [3:0]       hit_code_s;

  // Scan divider, column rotation and frame assembly.
  always_comb begin
    tick_s       = (div_q == DIV_LAST);
    frame_done_s = tick_s && (col_q == 2'd3);
    div_d        = tick_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    col_d        = tick_s ? col_q + 2'd1 : col_q;
    col_sel_d    = ~(4'b0001 << col_d);
    frame_full_s = frame_q;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_q == c[1:0]) begin
          frame_full_s[r*4+c] = ~row_sync_q[r];
        end else begin
          frame_full_s[r*4+c] = frame_q[r*4+c];
        end
      end
    end
    if (tick_s) begin
      frame_d = frame_done_s ? 16'h0000 : frame_full_s;
    end else begin
      frame_d = frame_q;
    end
  end

  // Frame classification: bit index of a lone hit is already {row, col}.
  always_comb begin
    ones_s     = 5'd0;
    hit_code_s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      ones_s = ones_s + {4'd0, frame_full_s[i]};
      if (frame_full_s[i]) begin
        hit_code_s = 4'(i);
      end else begin
        hit_code_s = hit_code_s;
      end
    end
    empty_s  = (ones_s == 5'd0);
    single_s = (ones_s == 5'd1);
  end

  // Debounce FSM next-state and registered output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    cnt_inc_s   = cnt_q + CNT_W'(1);
    if (frame_done_s) begin
      case (state_q)
        ST_IDLE: begin
          if (single_s && (DEBOUNCE_SCANS == 1)) begin
            state_d     = ST_HELD;
            key_code_d  = hit_code_s;
            key_valid_d = 1'b1;
          end else if (single_s) begin
            state_d = ST_PRESS;
            cand_d  = hit_code_s;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (single_s && (hit_code_s == cand_q)) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_DONE) begin
              state_d     = ST_HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end else begin
              state_d = ST_PRESS;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (empty_s && (DEBOUNCE_SCANS == 1)) begin
            state_d = ST_IDLE;
          end else if (empty_s) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (empty_s) begin
            cnt_d   = cnt_inc_s;
            state_d = (cnt_inc_s == CNT_DONE) ? ST_IDLE : ST_RELEASE;
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  // State registers; reset discards any partial frame and debounce progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      div_q       <= {DIV_W{1'b0}};
      col_q       <= 2'd0;
      col_sel_q   <= 4'b1110;
      frame_q     <= 16'h0000;
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_pins;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_q       <= col_d;
      col_sel_q   <= col_sel_d;
      frame_q     <= frame_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_select = col_sel_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_held   = key_held_q;

`ifdef KEYPAD_ENTRY_EN
  logic [15:0] entry_q, entry_d;

  // Shift accepted digits in; a coincident clear keeps only the new digit.
  always_comb begin
    entry_d = entry_q;
    if (key_valid_d && entry_clr) begin
      entry_d = {12'h000, key_code_d};
    end else if (key_valid_d) begin
      entry_d = {entry_q[11:0], key_code_d};
    end else if (entry_clr) begin
      entry_d = 16'h0000;
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= 16'h0000;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;
`else
  logic unused_entry_clr_s;
  assign unused_entry_clr_s = entry_clr;
  assign entry = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_pins;
  logic [3:0]  col_select;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        entry_clr;
  logic [15:0] entry;
  logic [15:0] keys;

  int checks = 0;
  int passed = 0;
  int pulse_cnt = 0;
  int dbl_cnt = 0;
  int base;
  logic prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_pins   (row_pins),
    .col_select (col_select),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .entry_clr  (entry_clr),
    .entry      (entry)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_pins[r] = ~|(keys[r*4 +: 4] & ~col_select);
    end
  end

  always @(negedge clk) begin
    if (key_valid) pulse_cnt++;
    if (key_valid && prev_valid) dbl_cnt++;
    prev_valid = key_valid;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    wait_clks(16 * n);
  endtask

  // Return on the negedge just after a frame-completing edge (column wraps to 0).
  task automatic align_frame();
    logic [3:0] prev;
    int n;
    prev = col_select;
    n = 0;
    @(negedge clk);
    while (!(col_select == 4'b1110 && prev != 4'b1110) && n < 40) begin
      prev = col_select;
      @(negedge clk);
      n++;
    end
    check_eq("align_bound", {15'd0, n < 40}, 16'd1);
  endtask

  task automatic press_key(input logic [3:0] code);
    keys = 16'd1 << code;
    wait_frames(4);
    keys = 16'h0000;
    wait_frames(4);
  endtask

  initial begin
    rst = 1'b1;
    entry_clr = 1'b0;
    keys = 16'h0000;
    wait_clks(2);
    rst = 1'b0;

    // Reset mid-scan
    wait_clks(6);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    check_eq("rst_col", {12'd0, col_select}, 16'h000E);
    check_eq("rst_code", {12'd0, key_code}, 16'h0000);
    check_eq("rst_valid", {15'd0, key_valid}, 16'h0000);
    check_eq("rst_held", {15'd0, key_held}, 16'h0000);
    check_eq("rst_entry", entry, 16'h0000);
    wait_clks(3);
    check_eq("rst_col_hold", {12'd0, col_select}, 16'h000E);
    wait_clks(1);
    check_eq("rst_col_adv", {12'd0, col_select}, 16'h000D);

    // Press and release key (2,1)
    base = pulse_cnt;
    align_frame();
    keys = 16'd1 << 9;
    align_frame();
    wait_clks(2);
    check_eq("press_early_held", {15'd0, key_held}, 16'h0000);
    align_frame();
    wait_clks(2);
    check_eq("press_code", {12'd0, key_code}, 16'h0009);
    check_eq("press_held", {15'd0, key_held}, 16'h0001);
    check_eq("press_pulses", 16'(pulse_cnt - base), 16'd1);
    keys = 16'h0000;
    align_frame();
    wait_clks(2);
    check_eq("release_1frame_held", {15'd0, key_held}, 16'h0001);
    align_frame();
    wait_clks(2);
    check_eq("release_held", {15'd0, key_held}, 16'h0000);
    check_eq("release_pulses", 16'(pulse_cnt - base), 16'd1);

    // Bounce on (0,3)
    base = pulse_cnt;
    align_frame();
    keys = 16'd1 << 3;
    align_frame();
    keys = 16'h0000;
    align_frame();
    keys = 16'd1 << 3;
    align_frame();
    wait_clks(2);
    check_eq("bounce_no_pulse", 16'(pulse_cnt - base), 16'd0);
    check_eq("bounce_not_held", {15'd0, key_held}, 16'h0000);
    align_frame();
    wait_clks(2);
    check_eq("bounce_pulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("bounce_code", {12'd0, key_code}, 16'h0003);
    check_eq("bounce_held", {15'd0, key_held}, 16'h0001);
    keys = 16'h0000;
    wait_frames(4);
    check_eq("bounce_released", {15'd0, key_held}, 16'h0000);

    // Ghosting: two keys from IDLE, then rollover while held
    base = pulse_cnt;
    keys = (16'd1 << 0) | (16'd1 << 7);
    wait_frames(4);
    check_eq("ghost_no_pulse", 16'(pulse_cnt - base), 16'd0);
    check_eq("ghost_not_held", {15'd0, key_held}, 16'h0000);
    keys = 16'd1 << 0;
    wait_frames(4);
    check_eq("k0_pulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("k0_code", {12'd0, key_code}, 16'h0000);
    check_eq("k0_held", {15'd0, key_held}, 16'h0001);
    keys = (16'd1 << 0) | (16'd1 << 15);
    wait_frames(3);
    check_eq("rollover_pulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("rollover_code", {12'd0, key_code}, 16'h0000);
    check_eq("rollover_held", {15'd0, key_held}, 16'h0001);
    keys = 16'h0000;
    wait_frames(4);
    check_eq("rollover_released", {15'd0, key_held}, 16'h0000);

    // Reset while debouncing (PRESS state)
    base = pulse_cnt;
    align_frame();
    keys = 16'd1 << 5;
    align_frame();
    wait_clks(5);
    rst = 1'b1;
    keys = 16'h0000;
    wait_clks(1);
    rst = 1'b0;
    check_eq("dbrst_col", {12'd0, col_select}, 16'h000E);
    check_eq("dbrst_valid", {15'd0, key_valid}, 16'h0000);
    check_eq("dbrst_held", {15'd0, key_held}, 16'h0000);
    check_eq("dbrst_code", {12'd0, key_code}, 16'h0000);
    wait_clks(3);
    check_eq("dbrst_col_hold", {12'd0, col_select}, 16'h000E);
    wait_clks(1);
    check_eq("dbrst_col_adv", {12'd0, col_select}, 16'h000D);
    wait_frames(3);
    check_eq("dbrst_no_pulse", 16'(pulse_cnt - base), 16'd0);

`ifdef KEYPAD_ENTRY_EN
    // Entry register: digits 1..5, then clear coincident with digit 6
    base = pulse_cnt;
    for (int k = 1; k <= 5; k++) press_key(4'(k));
    check_eq("entry_pulses", 16'(pulse_cnt - base), 16'd5);
    check_eq("entry_2345", entry, 16'h2345);
    align_frame();
    keys = 16'd1 << 6;
    align_frame();
    wait_clks(15);
    entry_clr = 1'b1;
    wait_clks(1);
    entry_clr = 1'b0;
    check_eq("entry6_valid", {15'd0, key_valid}, 16'h0001);
    check_eq("entry6_value", entry, 16'h0006);
    keys = 16'h0000;
    wait_frames(4);
    entry_clr = 1'b1;
    wait_clks(1);
    entry_clr = 1'b0;
    check_eq("entry_clr_only", entry, 16'h0000);
`else
    // Entry register absent: stays zero through a press and a clear request
    base = pulse_cnt;
    entry_clr = 1'b1;
    wait_clks(1);
    entry_clr = 1'b0;
    press_key(4'h1);
    check_eq("noentry_pulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("noentry_value", entry, 16'h0000);
`endif

    check_eq("valid_single_cycle", 16'(dbl_cnt), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex matrix keypad: drives one column low at a time, samples the row inputs, debounces whole-keypad scan frames, and reports each accepted key press as a 4-bit hex code with a one-cycle strobe. It is the input-side counterpart of the multiplexed 7-segment display path. It feeds the front panel used to enter values into the SAP-1 design. An optional entry register accumulates typed hex digits into a 16-bit value that can drive the display directly.

## Interface
- `SCAN_DIV`, 120: clk cycles each column is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical frames required to accept a press or release; must be ≥ 1.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row_pins`  in  4  keypad rows, active-low (external pull-ups), asynchronous; 2-FF synchronized internally.
- `col_select`  out  4  column drive, active-low, exactly one bit low at all times.
- `key_code`  out  4  code of the last accepted key, `{row[1:0], col[1:0]}`.
- `key_valid`  out  1  one-clk pulse when a press is accepted.
- `key_held`  out  1  high while the accepted key is debounced-pressed.
- `entry_clr`  in  1  clears the entry register (macro builds only).
- `entry`  out  16  hex entry register, newest digit in `[3:0]`.

## Operation
- **Divider:** counts 0..`SCAN_DIV`-1. A tick occurs when the count equals `SCAN_DIV`-1.
- **Column sampling:** on each tick, synchronized rows for the current column c are inverted and written to frame bits `[r*4+c]`. The column then advances c→c+1 and wraps 3→0.
- **Frame completion:** the tick that samples column 3 completes a frame. The frame is classified as:
  - EMPTY: 0 bits set.
  - SINGLE(code): exactly 1 bit set.
  - MULTI: ≥ 2 bits set.
- **FSM.** The counter `cnt` counts qualifying frames, including the first. All transitions are evaluated only on frame completion.
  - IDLE:
    - SINGLE(k) → `cand`=k, `cnt`=1, go to PRESS. If `DEBOUNCE_SCANS`=1, accept immediately instead.
    - EMPTY or MULTI → stay in IDLE.
  - PRESS:
    - SINGLE(`cand`) → `cnt`++. When `cnt` reaches `DEBOUNCE_SCANS`, accept: go to HELD, `key_code`←`cand`, pulse `key_valid`.
    - Any other frame → IDLE.
  - HELD:
    - EMPTY → `cnt`=1, go to RELEASE. If `DEBOUNCE_SCANS`=1, go straight to IDLE.
    - SINGLE or MULTI of any key → stay in HELD. There is no rollover; a second key is ignored until full release.
  - RELEASE:
    - EMPTY → `cnt`++. When `cnt` reaches `DEBOUNCE_SCANS`, go to IDLE.
    - Non-empty frame → HELD, with no new `key_valid`.
- **Outputs:**
  - `key_held` = 1 in HELD and RELEASE.
  - `key_code` holds its value until the next accepted press.
- **Reset:** a reset at any time returns to IDLE with no `key_valid` pulse. The partial frame, `cnt` and `cand` are discarded.

## Timing
- Reset values:
  - `col_select` = 4'b1110.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `entry` = 16'h0000.
  - Divider = 0, column = 0, frame = 0, state IDLE.
- Each column is driven for exactly `SCAN_DIV` clks. The frame period is 4·`SCAN_DIV` clks.
- Rows are sampled at the last clk of a column's window. The 2-FF sync latency (2 clks) is less than `SCAN_DIV`, so samples are settled.
- `key_valid` and `key_held` are registered. They rise on the clk edge following the frame-completing tick. `key_code` updates on that same edge.
- Minimum press latency from a stable press: up to `DEBOUNCE_SCANS`+1 frame periods, depending on scan phase.
- `key_valid` is never high for two consecutive clks.

## Configuration
- The macro `KEYPAD_ENTRY_EN` controls the entry register.
- **Defined:**
  - On each `key_valid`, `entry` ← `{entry[11:0], key_code}`, updating on the same edge as `key_valid`.
  - `entry_clr` synchronously sets `entry` = 0.
  - If `entry_clr` and `key_valid` coincide, `entry` = `{12'h000, key_code}`.
- **Undefined:** `entry` is tied to 16'h0000 and `entry_clr` is ignored.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=2. The bench models key (r,c) by pulling `row_pins[r]` low while `col_select[c]`=0.

- **Reset:** hold `rst` high for 3 clks mid-scan → `col_select`=4'b1110, all other outputs 0. The first column advance occurs 4 clks after `rst` deasserts.
- **Press and release:** hold key (2,1) steady → `key_code`=4'h9, exactly one `key_valid` pulse, `key_held`=1 within 3 frames. Release → `key_held`=0 after 2 empty frames, with no extra pulse.
- **Bounce:** press (0,3) for 1 frame, release for 1 frame, then press steadily → no pulse until 2 consecutive SINGLE frames, then one pulse with `key_code`=4'h3.
- **Ghosting and rollover:**
  - From IDLE, press (0,0) and (1,3) together → no `key_valid`, `key_held`=0.
  - While HELD on (0,0), add (3,3) → no new pulse, `key_code` stays 0.
- **Reset during debounce:** assert `rst` during PRESS → no pulse, outputs at reset values, and scanning restarts at column 0.
- **Entry register (`KEYPAD_ENTRY_EN`):** press keys 1,2,3,4,5 in turn → `entry`=16'h2345. Then assert `entry_clr` coincident with the `key_valid` for key 6 → `entry`=16'h0006.
